output_collector: RTL and testbench

- Sits directly downstream of the accelerator system and consumes its result stream: data plus x/y/ch coordinates, with no backpressure available.
- Checks the arrival order against the expected raster order.
- Packs pairs of IO_DATA_WIDTH results into 2*IO_DATA_WIDTH words and buffers them in a first-word-fall-through FIFO.
- Drains the FIFO to a host over a valid/ready handshake, and reports overflow, order errors and frame completion.

---
 rtl/output_collector.sv | 156 +++++++++++++++
 tb/tb_output_collector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_collector.sv
// output_collector: raster-order check, pair packing and FWFT FIFO toward a host; optional checksum via OUTPUT_COLLECTOR_CHECKSUM_EN
module output_collector #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FIFO_DEPTH         = 16,
  localparam int XW    = FEATURE_MAP_WIDTH > 1 ? $clog2(FEATURE_MAP_WIDTH) : 1,
  localparam int YW    = FEATURE_MAP_HEIGHT > 1 ? $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int CHW   = OUTPUT_NB_CHANNELS > 1 ? $clog2(OUTPUT_NB_CHANNELS) : 1,
  localparam int TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS,
  localparam int CW    = $clog2(TOTAL) + 1,
  localparam int DW    = IO_DATA_WIDTH,
  localparam int AW    = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  input  logic                 start,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  input  logic [XW-1:0]        in_x,
  input  logic [YW-1:0]        in_y,
  input  logic [CHW-1:0]       in_ch,
  output logic [2*DW-1:0]      host_data,
  output logic                 host_valid,
  input  logic                 host_ready,
  output logic                 overflow,
  output logic                 order_error,
  output logic                 frame_done,
  output logic [CW-1:0]        sample_count,
  output logic [2*DW-1:0]      checksum
);
  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;
  state_t state_q, state_d;
  logic [XW-1:0] ex_q, ex_d;
  logic [YW-1:0] ey_q, ey_d;
  logic [CHW-1:0] ec_q, ec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] pend_q, pend_d;
  logic pend_v_q, pend_v_d;
  logic ov_q, ov_d;
  logic oe_q, oe_d;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [2*DW-1:0] mem [FIFO_DEPTH];
  logic [2*DW-1:0] push_word;
  logic accept, last, push, pop, wr, full, empty, ch_wrap, x_wrap;
  assign empty = wp_q == rp_q;
  assign full = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
  assign pop = !empty && host_ready;
  assign last = cnt_q == CW'(TOTAL - 1);
  assign ch_wrap = ec_q == CHW'(OUTPUT_NB_CHANNELS - 1);
  assign x_wrap = ex_q == XW'(FEATURE_MAP_WIDTH - 1);
  assign host_valid = !empty;
  // idle output is forced to zero so the unreset storage never leaks out
  assign host_data = empty ? '0 : mem[rp_q[AW-1:0]];
  assign overflow = ov_q;
  assign order_error = oe_q;
  assign sample_count = cnt_q;
  // FSM state register
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state_q <= IDLE;
    else state_q <= state_d;
  end
  // FSM next state: start wins from any state, flush lasts one cycle
  always_comb begin
    state_d = state_q;
    if (start) state_d = COLLECT;
    else if (state_q == FLUSH) state_d = IDLE;
    else if (accept && last) state_d = FLUSH;
  end
  // FSM outputs: samples only count while collecting, and a start cycle drops its sample
  always_comb begin
    accept = state_q == COLLECT && in_valid && !start;
    frame_done = state_q == FLUSH;
  end
  // datapath next state: order tracking, pair packing, flush padding and FIFO pointer moves
  always_comb begin
    ex_d = ex_q;
    ey_d = ey_q;
    ec_d = ec_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    pend_v_d = pend_v_q;
    oe_d = oe_q;
    push = 1'b0;
    push_word = {in_data, pend_q};
    if (start) begin
      ex_d = '0;
      ey_d = '0;
      ec_d = '0;
      cnt_d = '0;
      pend_d = '0;
      pend_v_d = 1'b0;
      oe_d = 1'b0;
    end else if (accept) begin
      oe_d = oe_q | (in_x != ex_q) | (in_y != ey_q) | (in_ch != ec_q);
      ec_d = ch_wrap ? '0 : ec_q + 1'b1;
      ex_d = !ch_wrap ? ex_q : x_wrap ? '0 : ex_q + 1'b1;
      ey_d = ch_wrap && x_wrap ? ey_q + 1'b1 : ey_q;
      cnt_d = cnt_q + 1'b1;
      pend_d = cnt_q[0] ? pend_q : in_data;
      pend_v_d = !cnt_q[0];
      push = cnt_q[0];
    end else if (state_q == FLUSH && pend_v_q) begin
      push = 1'b1;
      push_word = {{DW{1'b0}}, pend_q};
      pend_v_d = 1'b0;
    end
    wr = push && (!full || pop);
    ov_d = !start && (ov_q || (push && full && !pop));
    wp_d = start ? '0 : wp_q + (AW+1)'(wr);
    rp_d = start ? '0 : rp_q + (AW+1)'(pop);
  end
  // datapath registers; reset discards queued words by rewinding both pointers
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      ex_q <= '0;
      ey_q <= '0;
      ec_q <= '0;
      cnt_q <= '0;
      pend_q <= '0;
      pend_v_q <= 1'b0;
      ov_q <= 1'b0;
      oe_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      ex_q <= ex_d;
      ey_q <= ey_d;
      ec_q <= ec_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      ov_q <= ov_d;
      oe_q <= oe_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  // FIFO storage write
  always_ff @(posedge clk) begin
    if (wr) mem[wp_q[AW-1:0]] <= push_word;
  end
`ifdef OUTPUT_COLLECTOR_CHECKSUM_EN
  logic [2*DW-1:0] cs_q;
  // running sum of every packed word offered to the FIFO, dropped ones included
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) cs_q <= '0;
    else if (start) cs_q <= '0;
    else if (push) cs_q <= cs_q + push_word;
  end
  assign checksum = cs_q;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_output_collector.sv
// tb_output_collector: randomized scenarios against a queue-based reference of the collector
module tb_output_collector;
  localparam int DW = 16, W = 3, H = 3, C = 3, D = 4, TOTAL = W * H * C;
`ifdef OUTPUT_COLLECTOR_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif
  logic clk = 1'b0, arst_n_in = 1'b0, start = 1'b0, in_valid = 1'b0, host_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [1:0] in_x = '0, in_y = '0, in_ch = '0;
  logic [2*DW-1:0] host_data, checksum;
  logic host_valid, overflow, order_error, frame_done;
  logic [5:0] sample_count;
  int total = 0, bad = 0, dut_done = 0, exp_done = 0;
  logic [2*DW-1:0] mq[$], rx[$], erx[$];
  logic [DW-1:0] m_pend, dat[TOTAL];
  bit m_pv, m_act, m_fl, m_ov, m_oe;
  int m_cnt;
  logic [2*DW-1:0] m_cs;

  always #5 clk = ~clk;

  output_collector #(.IO_DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
    .OUTPUT_NB_CHANNELS(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_x(in_x), .in_y(in_y), .in_ch(in_ch), .host_data(host_data), .host_valid(host_valid),
    .host_ready(host_ready), .overflow(overflow), .order_error(order_error),
    .frame_done(frame_done), .sample_count(sample_count), .checksum(checksum));

  task automatic m_clear();
    mq.delete();
    m_pv = 0; m_act = 0; m_fl = 0; m_ov = 0; m_oe = 0; m_cnt = 0; m_cs = '0;
  endtask

  // one clock: drive at negedge, record host transfers, advance the model, return at next negedge
  task automatic step(input bit s, input bit v, input bit r, input logic [DW-1:0] d,
                      input int x, input int y, input int ch);
    int sz;
    bit pp, psh;
    logic [2*DW-1:0] w;
    start = s; in_valid = v; host_ready = r; in_data = d;
    in_x = 2'(x); in_y = 2'(y); in_ch = 2'(ch);
    #1;
    if (host_valid && host_ready) rx.push_back(host_data);
    sz = mq.size();
    pp = r && sz > 0;
    if (pp) erx.push_back(mq[0]);
    psh = 0;
    w = '0;
    if (s) begin
      m_clear();
      m_act = 1;
    end else begin
      if (m_fl) begin
        if (m_pv) begin psh = 1; w = {{DW{1'b0}}, m_pend}; m_pv = 0; end
        m_fl = 0;
      end else if (m_act && v) begin
        if (x != (m_cnt / C) % W || y != m_cnt / (C * W) || ch != m_cnt % C) m_oe = 1;
        if (m_cnt % 2 == 0) begin m_pend = d; m_pv = 1; end
        else begin psh = 1; w = {d, m_pend}; m_pv = 0; end
        m_cnt++;
        if (m_cnt == TOTAL) begin m_act = 0; m_fl = 1; end
      end
      if (pp) void'(mq.pop_front());
      if (psh) begin
        m_cs += w;
        if (sz == D && !pp) m_ov = 1;
        else mq.push_back(w);
      end
    end
    @(posedge clk);
    @(negedge clk);
    dut_done += int'(frame_done);
    exp_done += int'(m_fl);
  endtask

  task automatic test_reset();
    total++; if (host_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", host_valid); end
    total++; if (host_data !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", host_data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    total++; if (order_error !== 1'b0) begin bad++; $display("FAIL rst_oe: got %b want 0", order_error); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", frame_done); end
    total++; if (sample_count !== '0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", sample_count); end
    total++; if (checksum !== '0) begin bad++; $display("FAIL rst_cs: got %h want 0", checksum); end
    repeat (3) step(0, 1, 1, 16'($urandom), 0, 0, 0);
    total++; if (sample_count !== '0) begin bad++; $display("FAIL idle_cnt: got %0d want 0", sample_count); end
    total++; if (host_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", host_valid); end
  endtask

  task automatic test_frame();
    rx.delete(); erx.delete(); dut_done = 0; exp_done = 0;
    step(1, 0, 1, '0, 0, 0, 0);
    for (int i = 0; i < TOTAL; i++) step(0, 1, 1, 16'(i + 1), (i / C) % W, i / (C * W), i % C);
    repeat (4) step(0, 0, 1, '0, 0, 0, 0);
    total++; if (rx.size() != 14) begin bad++; $display("FAIL frame_words: got %0d want 14", rx.size()); end
    foreach (erx[i]) begin
      total++; if (rx.size() <= i || rx[i] !== erx[i]) begin bad++; $display("FAIL frame_word%0d: got %h want %h", i, rx.size() > i ? rx[i] : 'x, erx[i]); end
    end
    total++; if (rx[0] !== 32'h00020001) begin bad++; $display("FAIL frame_first: got %h want 00020001", rx[0]); end
    total++; if (rx[13] !== 32'h0000001B) begin bad++; $display("FAIL frame_pad: got %h want 0000001b", rx[13]); end
    total++; if (dut_done != 1) begin bad++; $display("FAIL frame_done_cnt: got %0d want 1", dut_done); end
    total++; if (overflow !== 1'b0 || order_error !== 1'b0) begin bad++; $display("FAIL frame_flags: got ovf=%b oe=%b want 0 0", overflow, order_error); end
    total++; if (sample_count !== 6'(TOTAL)) begin bad++; $display("FAIL frame_cnt: got %0d want %0d", sample_count, TOTAL); end
    total++; if (checksum !== (CS_EN ? 32'h00B600C4 : 32'h0)) begin bad++; $display("FAIL frame_cs: got %h want %h", checksum, CS_EN ? 32'h00B600C4 : 32'h0); end
  endtask

  task automatic test_order_error();
    int j;
    rx.delete(); erx.delete();
    step(1, 0, 1, '0, 0, 0, 0);
    for (int i = 0; i < TOTAL; i++) begin
      j = i == 2 ? 3 : i == 3 ? 2 : i;
      step(0, 1, 1, 16'($urandom), (j / C) % W, j / (C * W), j % C);
    end
    repeat (4) step(0, 0, 1, '0, 0, 0, 0);
    total++; if (order_error !== 1'b1) begin bad++; $display("FAIL oe_set: got %b want 1", order_error); end
    total++; if (rx.size() != 14) begin bad++; $display("FAIL oe_words: got %0d want 14", rx.size()); end
    foreach (erx[i]) begin
      total++; if (rx.size() <= i || rx[i] !== erx[i]) begin bad++; $display("FAIL oe_word%0d: got %h want %h", i, rx.size() > i ? rx[i] : 'x, erx[i]); end
    end
    repeat (3) step(0, 1, 1, 16'($urandom), 0, 0, 0);
    total++; if (order_error !== 1'b1) begin bad++; $display("FAIL oe_sticky: got %b want 1", order_error); end
    step(1, 0, 1, '0, 0, 0, 0);
    total++; if (order_error !== 1'b0) begin bad++; $display("FAIL oe_clear: got %b want 0", order_error); end
  endtask

  task automatic test_overflow();
    rx.delete(); erx.delete();
    step(1, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < TOTAL; i++) begin
      dat[i] = 16'($urandom);
      step(0, 1, 0, dat[i], (i / C) % W, i / (C * W), i % C);
    end
    repeat (2) step(0, 0, 0, '0, 0, 0, 0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    repeat (8) step(0, 0, 1, '0, 0, 0, 0);
    total++; if (rx.size() != 4) begin bad++; $display("FAIL ovf_words: got %0d want 4", rx.size()); end
    foreach (erx[i]) begin
      total++; if (rx.size() <= i || rx[i] !== erx[i]) begin bad++; $display("FAIL ovf_word%0d: got %h want %h", i, rx.size() > i ? rx[i] : 'x, erx[i]); end
    end
    total++; if (rx[3] !== {dat[7], dat[6]}) begin bad++; $display("FAIL ovf_last: got %h want %h", rx[3], {dat[7], dat[6]}); end
    total++; if (checksum !== (CS_EN ? m_cs : 32'h0)) begin bad++; $display("FAIL ovf_cs: got %h want %h", checksum, CS_EN ? m_cs : 32'h0); end
  endtask

  task automatic test_full_push_pop();
    rx.delete(); erx.delete();
    step(1, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 12; i++) dat[i] = 16'(100 + i);
    for (int i = 0; i < 10; i++) step(0, 1, i == 9, dat[i], (i / C) % W, i / (C * W), i % C);
    repeat (2) step(0, 0, 0, '0, 0, 0, 0);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_ovf: got %b want 0", overflow); end
    total++; if (host_valid !== 1'b1) begin bad++; $display("FAIL pp_valid: got %b want 1", host_valid); end
    for (int i = 10; i < 12; i++) step(0, 1, 0, dat[i], (i / C) % W, i / (C * W), i % C);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL pp_full: got %b want 1", overflow); end
    repeat (6) step(0, 0, 1, '0, 0, 0, 0);
    total++; if (rx.size() != 5) begin bad++; $display("FAIL pp_words: got %0d want 5", rx.size()); end
    foreach (erx[i]) begin
      total++; if (rx.size() <= i || rx[i] !== erx[i]) begin bad++; $display("FAIL pp_word%0d: got %h want %h", i, rx.size() > i ? rx[i] : 'x, erx[i]); end
    end
    total++; if (rx[4] !== {dat[9], dat[8]}) begin bad++; $display("FAIL pp_last: got %h want %h", rx[4], {dat[9], dat[8]}); end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 16'($urandom), (i / C) % W, i / (C * W), i % C);
    total++; if (host_valid !== 1'b1) begin bad++; $display("FAIL ar_queued: got %b want 1", host_valid); end
    #2 arst_n_in = 1'b0;
    #1;
    total++; if (host_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", host_valid); end
    total++; if (sample_count !== '0) begin bad++; $display("FAIL ar_cnt: got %0d want 0", sample_count); end
    m_clear();
    @(negedge clk);
    arst_n_in = 1'b1;
    rx.delete(); erx.delete();
    step(1, 0, 1, '0, 0, 0, 0);
    for (int i = 0; i < TOTAL; i++) begin
      dat[i] = 16'h5000 + 16'(i);
      step(0, 1, 1, dat[i], (i / C) % W, i / (C * W), i % C);
    end
    repeat (4) step(0, 0, 1, '0, 0, 0, 0);
    total++; if (rx.size() != 14) begin bad++; $display("FAIL ar_words: got %0d want 14", rx.size()); end
    total++; if (rx[0] !== 32'h50015000) begin bad++; $display("FAIL ar_first: got %h want 50015000", rx[0]); end
    foreach (erx[i]) begin
      total++; if (rx.size() <= i || rx[i] !== erx[i]) begin bad++; $display("FAIL ar_word%0d: got %h want %h", i, rx.size() > i ? rx[i] : 'x, erx[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int i, n;
    bit r, e;
    for (int f = 0; f < 5; f++) begin
      rx.delete(); erx.delete(); dut_done = 0; exp_done = 0;
      step(1, f % 2 == 1, 1, 16'($urandom), 0, 0, 0);
      n = f == 1 ? 10 : TOTAL;
      i = 0;
      while (i < n) begin
        r = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 3) == 0) step(0, 0, r, 16'($urandom), 0, 0, 0);
        else begin
          e = $urandom_range(0, 19) == 0;
          step(0, 1, r, 16'($urandom), e ? (i / C + 1) % W : (i / C) % W, i / (C * W), i % C);
          i++;
        end
      end
      if (f != 1) begin
        repeat (12) step(0, 0, 1, '0, 0, 0, 0);
        total++; if (rx.size() != erx.size()) begin bad++; $display("FAIL b2b%0d_words: got %0d want %0d", f, rx.size(), erx.size()); end
        foreach (erx[k]) begin
          total++; if (rx.size() <= k || rx[k] !== erx[k]) begin bad++; $display("FAIL b2b%0d_word%0d: got %h want %h", f, k, rx.size() > k ? rx[k] : 'x, erx[k]); end
        end
        total++; if (overflow !== m_ov || order_error !== m_oe) begin bad++; $display("FAIL b2b%0d_flags: got ovf=%b oe=%b want %b %b", f, overflow, order_error, m_ov, m_oe); end
        total++; if (sample_count !== 6'(m_cnt)) begin bad++; $display("FAIL b2b%0d_cnt: got %0d want %0d", f, sample_count, m_cnt); end
        total++; if (dut_done != exp_done) begin bad++; $display("FAIL b2b%0d_done: got %0d want %0d", f, dut_done, exp_done); end
        total++; if (checksum !== (CS_EN ? m_cs : 32'h0)) begin bad++; $display("FAIL b2b%0d_cs: got %h want %h", f, checksum, CS_EN ? m_cs : 32'h0); end
      end
    end
  endtask

  initial begin
    m_clear();
    #12;
    @(negedge clk);
    arst_n_in = 1'b1;
    test_reset();
    test_frame();
    test_order_error();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
